// File: rtl/serial_addsub_n.sv
// ============================================================================
// serial_addsub_n : bit-serial (LSB-first) adder/subtractor, WIDTH+1 cycles/op
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic accept;
  logic last_bit;
  logic sum_bit;
  logic carry_nxt;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_bit  = (state == RUN) && (cnt == LAST_BIT);
  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~cin, so the inverted borrow-in seeds the carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      S      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= sub ? ~B : B;
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= (res_sr >> 1) | ((WIDTH-1)'(sum_bit) << (WIDTH - 2));
      carry  <= carry_nxt;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        // carry still holds the carry into the MSB at this point
        S    <= {sum_bit, res_sr};
        cout <= carry_nxt;
        ovf  <= carry ^ carry_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_n.sv
// ============================================================================
// tb_serial_addsub_n : scoreboard bench for serial_addsub_n (WIDTH 8 and 16)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_addsub_n;

  localparam int W = 8;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, cin, sub;
  logic [7:0] a, b, s;
  logic       cout, ovf, busy, done;

  logic        start16, cin16, sub16;
  logic [15:0] a16, b16, s16;
  logic        cout16, ovf16, busy16, done16;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_addsub_n #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .cin(cin), .sub(sub),
    .S(s), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  serial_addsub_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .cin(cin16), .sub(sub16),
    .S(s16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
  );

  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    logic [16:0] full;
    logic [15:0] mask;
    exp_t        e;
    int          m;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    x    = x & mask;
    y    = y & mask;
    m    = w - 1;
    if (!sb) full = {1'b0, x} + {1'b0, y} + {16'h0, ci};
    else     full = {1'b0, x} - {1'b0, y} - {16'h0, ci};
    e.s    = full[15:0] & mask;
    e.cout = sb ? ~full[w] : full[w];
    e.ovf  = sb ? ((x[m] != y[m]) && (e.s[m] != x[m]))
                : ((x[m] == y[m]) && (e.s[m] != x[m]));
    return e;
  endfunction

  // One-edge start pulse on the 8-bit DUT; expected result queued at drive time.
  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic sb);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
    exp_q.push_back(model(8, {8'h00, x}, {8'h00, y}, ci, sb));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (!done && edges < lim) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({s, cout, ovf, busy, done} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got S=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               s, cout, ovf, busy, done);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_add;
    logic [7:0] xs[7] = '{8'h3C, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ys[7] = '{8'h0F, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       cs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int edges, bc;
    exp_t e;
    for (int i = 3; i < 7; i++) begin
      xs[i] = 8'($urandom_range(0, 255));
      ys[i] = 8'($urandom_range(0, 255));
      cs[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 7; i++) begin
      issue(xs[i], ys[i], cs[i], 1'b0);
      wait_done(40, edges, bc);
      e = exp_q.pop_front();
      n_cmp++;
      if (edges !== W) begin
        n_bad++;
        $display("FAIL add_latency[%0d]: got %0d edges, want %0d", i, edges, W);
      end
      n_cmp++;
      if (bc !== W) begin
        n_bad++;
        $display("FAIL add_busy_cycles[%0d]: got %0d, want %0d", i, bc, W);
      end
      n_cmp++;
      if ({s, cout, ovf} !== {e.s[7:0], e.cout, e.ovf}) begin
        n_bad++;
        $display("FAIL add_result[%0d] %h+%h+%b: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
                 i, xs[i], ys[i], cs[i], s, cout, ovf, e.s[7:0], e.cout, e.ovf);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({done, busy, s, cout, ovf} !== {2'b00, e.s[7:0], e.cout, e.ovf}) begin
        n_bad++;
        $display("FAIL add_hold[%0d]: got done=%b busy=%b S=%h cout=%b ovf=%b, want done=0 busy=0 S=%h",
                 i, done, busy, s, cout, ovf, e.s[7:0]);
      end
    end
  endtask

  task automatic test_sub;
    logic [7:0] xs[6] = '{8'h05, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ys[6] = '{8'h07, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       cs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int edges, bc;
    exp_t e;
    for (int i = 3; i < 6; i++) begin
      xs[i] = 8'($urandom_range(0, 255));
      ys[i] = 8'($urandom_range(0, 255));
      cs[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 6; i++) begin
      issue(xs[i], ys[i], cs[i], 1'b1);
      wait_done(40, edges, bc);
      e = exp_q.pop_front();
      n_cmp++;
      if (edges !== W) begin
        n_bad++;
        $display("FAIL sub_latency[%0d]: got %0d edges, want %0d", i, edges, W);
      end
      n_cmp++;
      if ({s, cout, ovf} !== {e.s[7:0], e.cout, e.ovf}) begin
        n_bad++;
        $display("FAIL sub_result[%0d] %h-%h-%b: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
                 i, xs[i], ys[i], cs[i], s, cout, ovf, e.s[7:0], e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_ignore_start;
    int edges, bc;
    exp_t e;
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_busy: got busy=%b, want 1", busy);
    end
    wait_done(40, edges, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (edges + 3 !== W) begin
      n_bad++;
      $display("FAIL ignore_latency: got %0d edges, want %0d", edges + 3, W);
    end
    n_cmp++;
    if ({s, cout, ovf} !== {e.s[7:0], e.cout, e.ovf}) begin
      n_bad++;
      $display("FAIL ignore_result: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
               s, cout, ovf, e.s[7:0], e.cout, e.ovf);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL ignore_no_restart: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int edges, bc;
    exp_t e1, e2;
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done(40, edges, bc);
    e1 = exp_q.pop_front();
    n_cmp++;
    if ({s, cout, ovf} !== {e1.s[7:0], e1.cout, e1.ovf}) begin
      n_bad++;
      $display("FAIL b2b_first: got S=%h cout=%b ovf=%b, want S=%h", s, cout, ovf, e1.s[7:0]);
    end
    a = 8'h55; b = 8'h22; cin = 1'b1; sub = 1'b1; start = 1'b1;
    exp_q.push_back(model(8, 16'h0055, 16'h0022, 1'b1, 1'b1));
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({busy, done, s} !== {2'b10, e1.s[7:0]}) begin
      n_bad++;
      $display("FAIL b2b_accept: got busy=%b done=%b S=%h, want busy=1 done=0 S=%h",
               busy, done, s, e1.s[7:0]);
    end
    wait_done(40, edges, bc);
    e2 = exp_q.pop_front();
    n_cmp++;
    if (edges !== W) begin
      n_bad++;
      $display("FAIL b2b_latency: got %0d edges, want %0d", edges, W);
    end
    n_cmp++;
    if ({s, cout, ovf} !== {e2.s[7:0], e2.cout, e2.ovf}) begin
      n_bad++;
      $display("FAIL b2b_second: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
               s, cout, ovf, e2.s[7:0], e2.cout, e2.ovf);
    end
  endtask

  task automatic test_reset_midrun;
    int edges, bc, pulses;
    exp_t e;
    issue(8'hA5, 8'h5A, 1'b1, 1'b0);
    void'(exp_q.pop_back());
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({s, cout, ovf, busy, done} !== 12'h000) begin
      n_bad++;
      $display("FAIL midrun_reset: got S=%h cout=%b ovf=%b busy=%b done=%b, want all 0",
               s, cout, ovf, busy, done);
    end
    start = 1'b1; a = 8'h01; b = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || s !== 8'h00) begin
      n_bad++;
      $display("FAIL midrun_quiet: got %0d busy/done cycles S=%h, want 0 cycles S=00", pulses, s);
    end
    issue(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_done(40, edges, bc);
    e = exp_q.pop_front();
    n_cmp++;
    if (edges !== W || {s, cout, ovf} !== {e.s[7:0], e.cout, e.ovf}) begin
      n_bad++;
      $display("FAIL midrun_fresh: got %0d edges S=%h cout=%b ovf=%b, want %0d edges S=%h cout=%b ovf=%b",
               edges, s, cout, ovf, W, e.s[7:0], e.cout, e.ovf);
    end
  endtask

  task automatic test_width16;
    logic [15:0] xs[3] = '{16'hFFFF, 16'h7FFF, 16'h8000};
    logic [15:0] ys[3] = '{16'h0001, 16'h0001, 16'h0001};
    logic        ss[3] = '{1'b0, 1'b0, 1'b1};
    int edges;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a16 = xs[i]; b16 = ys[i]; cin16 = 1'b0; sub16 = ss[i]; start16 = 1'b1;
      exp_q.push_back(model(16, xs[i], ys[i], 1'b0, ss[i]));
      @(posedge clk); #1;
      start16 = 1'b0;
      edges = 0;
      while (!done16 && edges < 60) begin
        @(posedge clk); #1;
        edges++;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (edges !== 16) begin
        n_bad++;
        $display("FAIL w16_latency[%0d]: got %0d edges, want 16", i, edges);
      end
      n_cmp++;
      if ({s16, cout16, ovf16} !== {e.s, e.cout, e.ovf}) begin
        n_bad++;
        $display("FAIL w16_result[%0d]: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
                 i, s16, cout16, ovf16, e.s, e.cout, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_ignore_start;
    test_back_to_back;
    test_reset_midrun;
    test_width16;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/serial_addsub_n.md
SERIAL_ADDSUB_N -- requirements
Module: serial_addsub_n

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 The module SHALL have the following ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse; operands sampled on the edge where accepted.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  mode: 0 = add, 1 = subtract.
- S  output  WIDTH  registered result.
- cout  output  1  carry-out (add) / not-borrow (sub).
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high while a bit-serial operation is running.
- done  output  1  one-cycle pulse when S/cout/ovf are updated.

Function
REQ-003 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-004 start SHALL be accepted only in IDLE or DONE; on acceptance A, B (bitwise inverted when sub=1) load into internal shift registers, carry register loads cin (sub=0) or ~cin (sub=1), bit counter clears, state goes to RUN.
REQ-005 start while in RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-006 In RUN, each edge SHALL process one bit, LSB first: full-add of the two operand LSBs and the carry register; sum bit shifts into the MSB of an internal result register; operand registers shift right; carry register updates; counter increments.
REQ-007 After the WIDTH-th RUN edge, state SHALL go to DONE; on that same edge S loads the internal result, cout loads the final carry, ovf loads (carry into MSB XOR carry out of MSB).
REQ-008 Latency: start sampled on edge k; done SHALL be high for exactly the cycle following edge k+WIDTH, and low otherwise.
REQ-009 DONE lasts one cycle, then IDLE unless start is accepted in DONE (back-to-back, next done at edge +WIDTH again); throughput one result per WIDTH+1 cycles.
REQ-010 busy SHALL be 1 exactly while in RUN.
REQ-011 S, cout, ovf SHALL hold their last value from DONE until the next DONE; partial sums SHALL never appear on S.
REQ-012 Arithmetic: sub=0 gives S = (A+B+cin) mod 2^WIDTH, cout = bit WIDTH of the true sum; sub=1 gives S = (A-B-cin) mod 2^WIDTH, cout = 1 when no borrow occurred.
REQ-013 Operand inputs SHALL be don't-care except on the accept edge; changes during RUN SHALL NOT affect the result.

Reset
REQ-014 rst=0 SHALL asynchronously force IDLE and clear S, cout, ovf, busy, done, shift registers, carry register and counter to 0, regardless of the current state (including mid-RUN).
REQ-015 While rst=0, start SHALL be ignored; the first accept is possible on the first rising edge with rst=1.

Verification (WIDTH=8 unless noted)
REQ-016 Add 0x3C+0x0F, cin=0 -> done 8 edges after accept, S=0x4B, cout=0, ovf=0; busy high for exactly 8 cycles.
REQ-017 Add 0x7F+0x01 cin=0 -> S=0x80, cout=0, ovf=1; add 0xFF+0x01 cin=1 -> S=0x01, cout=1, ovf=0.
REQ-018 Sub 0x05-0x07 cin=0 -> S=0xFE, cout=0, ovf=0; sub 0x80-0x01 cin=0 -> S=0x7F, cout=1, ovf=1.
REQ-019 start re-pulsed with new operands at the 3rd RUN cycle -> ignored, first result unchanged; start held high in DONE -> second op accepted, its done 8 edges later.
REQ-020 rst pulsed low at the 4th RUN cycle -> S=0, cout=0, ovf=0, busy=0, done never pulses; a fresh op afterwards gives a correct result.
REQ-021 WIDTH=16: 0xFFFF+0x0001 cin=0 -> done 16 edges after accept, S=0x0000, cout=1, ovf=0.
